// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe generator slice.
package pipe_pkg;

    // Generator sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPACE = 2'd1,
        PIPE  = 2'd2
    } pipe_state_t;

    // Feedback taps for x^8+x^6+x^5+x^4+1, bit n of the mask is q[n].
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Playfield height used when the top is not overridden.
    localparam int ROWS_DEFAULT = 16;

endpackage

// File: rtl/pipe_lfsr.sv
// 8-bit Fibonacci LFSR that feeds the gap position of each new pipe.
module pipe_lfsr
    import pipe_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [7:0] q
);

    // Shift left one place per step, feeding the XOR of the tapped bits into bit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SEED;
        end else if (step) begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/pipe_generator.sv
// Column source for the scrolling playfield: SPACING blank columns, then a
// PIPE_W-wide pipe with a pseudo-random GAP_H-row opening, repeating.
// Optional feature macro PIPE_RAMP_EN: every 4th pipe shortens the blank run
// by one column, down to SPACING_MIN.
module pipe_generator
    import pipe_pkg::*;
#(
    parameter int         ROWS        = ROWS_DEFAULT,
    parameter int         GAP_H       = 4,
    parameter int         PIPE_W      = 2,
    parameter int         SPACING     = 6,
    parameter int         SPACING_MIN = 3,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            run,
    output logic [ROWS-1:0] new_pipe,
    output logic            pipe_start,
    output logic [3:0]      gap_top,
    output logic [7:0]      pipe_count
);

    // Highest row index at which a gap may begin and still fit inside the field.
    localparam int GAP_MAX = ROWS - GAP_H;

    pipe_state_t state;
    logic [7:0]  cnt;
    logic [7:0]  lfsr_q;
    logic [3:0]  gap_sel;
    logic [7:0]  count_inc;
    logic        entering;
    logic [7:0]  cur_spacing;
    logic        unused_lfsr_hi;

    // Only the low nibble picks the gap; the rest of the state just scrambles it.
    assign unused_lfsr_hi = ^lfsr_q[7:4];

    pipe_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (enable),
        .q    (lfsr_q)
    );

    // Fold out-of-range nibbles back into the legal gap range.
    always_comb begin
        gap_sel = lfsr_q[3:0];
        if (int'(lfsr_q[3:0]) > GAP_MAX) begin
            gap_sel = 4'(int'(lfsr_q[3:0]) - GAP_MAX - 1);
        end
    end

    // Saturating next value of the pipe counter and the pipe-entry condition.
    always_comb begin
        count_inc = (pipe_count == 8'hFF) ? 8'hFF : pipe_count + 8'd1;
        entering  = enable && run && (state == SPACE) && (cnt == 8'd0);
    end

    // A pipe column is solid everywhere except the GAP_H rows starting at top.
    function automatic logic [ROWS-1:0] build_column(input logic [3:0] top);
        logic [ROWS-1:0] col;
        col = '0;
        for (int i = 0; i < ROWS; i++) begin
            col[i] = (i < int'(top)) || (i >= int'(top) + GAP_H);
        end
        return col;
    endfunction

`ifdef PIPE_RAMP_EN
    // Shorten the blank run after every 4th pipe, never below the floor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_spacing <= 8'(SPACING);
        end else if (!run) begin
            cur_spacing <= 8'(SPACING);
        end else if (entering && (count_inc[1:0] == 2'b00) &&
                     (int'(cur_spacing) > SPACING_MIN)) begin
            cur_spacing <= cur_spacing - 8'd1;
        end
    end
`else
    localparam int unused_spacing_min = SPACING_MIN;
    assign cur_spacing = 8'(SPACING);
`endif

    // Sequencer: run low parks everything, otherwise each enable writes one column.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            new_pipe   <= '0;
            pipe_start <= 1'b0;
            gap_top    <= 4'd0;
            pipe_count <= 8'd0;
        end else if (!run) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            new_pipe   <= '0;
            pipe_start <= 1'b0;
            pipe_count <= 8'd0;
        end else if (enable) begin
            pipe_start <= 1'b0;
            case (state)
                IDLE: begin
                    new_pipe <= '0;
                    cnt      <= cur_spacing - 8'd1;
                    state    <= SPACE;
                end
                SPACE: begin
                    if (cnt != 8'd0) begin
                        new_pipe <= '0;
                        cnt      <= cnt - 8'd1;
                    end else begin
                        gap_top    <= gap_sel;
                        new_pipe   <= build_column(gap_sel);
                        cnt        <= 8'(PIPE_W - 1);
                        pipe_start <= 1'b1;
                        pipe_count <= count_inc;
                        state      <= PIPE;
                    end
                end
                PIPE: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        new_pipe <= '0;
                        cnt      <= cur_spacing - 8'd1;
                        state    <= SPACE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end else begin
            pipe_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_generator.sv
// Directed bench for pipe_generator; expected ramp lengths follow PIPE_RAMP_EN.
module tb_pipe_generator;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        run;
    logic [15:0] new_pipe;
    logic        pipe_start;
    logic [3:0]  gap_top;
    logic [7:0]  pipe_count;

    int n_compared;
    int n_mismatched;

    pipe_generator dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .run        (run),
        .new_pipe   (new_pipe),
        .pipe_start (pipe_start),
        .gap_top    (gap_top),
        .pipe_count (pipe_count)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One enable pulse every 4th clock; returns on the falling edge after it.
    task automatic apply_tick();
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic apply_ticks(input int n);
        for (int i = 0; i < n; i++) apply_tick();
    endtask

    task automatic do_reset();
        run    = 1'b0;
        enable = 1'b0;
        rst    = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_new_pipe",   32'(new_pipe),   32'h0);
        check_output("rst_pipe_start", 32'(pipe_start), 32'h0);
        check_output("rst_gap_top",    32'(gap_top),    32'h0);
        check_output("rst_pipe_count", 32'(pipe_count), 32'h0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    function automatic int exp_zero_run(input int pipe_idx);
`ifdef PIPE_RAMP_EN
        if (pipe_idx <= 4) return 6;
        else if (pipe_idx <= 8) return 5;
        else if (pipe_idx <= 12) return 4;
        else return 3;
`else
        return 6;
`endif
    endfunction

    // Enables with run low before run rises, and the resulting gap and column.
    int          gap_pre [3] = '{10, 14, 35};
    logic [3:0]  gap_exp [3] = '{4'd12, 4'd2, 4'd5};
    logic [15:0] col_exp [3] = '{16'h0FFF, 16'hFFC3, 16'hFE1F};

    initial begin
        int zero_run;
        int pipes;
        int guard;
        n_compared   = 0;
        n_mismatched = 0;
        rst    = 1'b0;
        run    = 1'b0;
        enable = 1'b0;

        // Basic cadence from the seed: six blanks, two pipe columns, blanks again.
        do_reset();
        run = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            apply_tick();
            check_output($sformatf("t1_blank%0d", i), 32'(new_pipe), 32'h0);
            check_output($sformatf("t1_nostart%0d", i), 32'(pipe_start), 32'h0);
        end
        apply_tick();
        check_output("t1_col7",   32'(new_pipe),   32'hFF87);
        check_output("t1_start7", 32'(pipe_start), 32'h1);
        check_output("t1_gap7",   32'(gap_top),    32'h3);
        check_output("t1_count7", 32'(pipe_count), 32'h1);
        repeat (2) @(negedge clk);
        check_output("t1_hold_col",   32'(new_pipe),   32'hFF87);
        check_output("t1_hold_start", 32'(pipe_start), 32'h0);
        apply_tick();
        check_output("t1_col8",   32'(new_pipe),   32'hFF87);
        check_output("t1_start8", 32'(pipe_start), 32'h0);
        apply_tick();
        check_output("t1_col9",   32'(new_pipe),   32'h0);
        apply_ticks(5);
        check_output("t1_col14",  32'(new_pipe),   32'h0);
        apply_tick();
        check_output("t1_col15",  32'(new_pipe),   32'h87FF);
        check_output("t1_gap15",  32'(gap_top),    32'hB);
        check_output("t1_count15", 32'(pipe_count), 32'h2);

        // Gap folding and boundary positions chosen by pre-advancing the LFSR.
        for (int k = 0; k < 3; k++) begin
            do_reset();
            apply_ticks(gap_pre[k]);
            run = 1'b1;
            apply_ticks(7);
            check_output($sformatf("gap%0d_top", k),   32'(gap_top),    32'(gap_exp[k]));
            check_output($sformatf("gap%0d_col", k),   32'(new_pipe),   32'(col_exp[k]));
            check_output($sformatf("gap%0d_start", k), 32'(pipe_start), 32'h1);
        end

        // run falling mid-pipe clears on the next clock with no enable.
        do_reset();
        run = 1'b1;
        apply_ticks(7);
        run = 1'b0;
        @(negedge clk);
        check_output("t4_col",   32'(new_pipe),   32'h0);
        check_output("t4_count", 32'(pipe_count), 32'h0);
        run = 1'b1;
        zero_run = 0;
        for (int i = 1; i <= 6; i++) begin
            apply_tick();
            if (pipe_start == 1'b0 && new_pipe == 16'h0) zero_run++;
        end
        check_output("t4_idle_blanks", 32'(zero_run), 32'd6);
        apply_tick();
        check_output("t4_restart", 32'(pipe_start), 32'h1);

        // Asynchronous reset between edges while a pipe is being written.
        do_reset();
        run = 1'b1;
        apply_ticks(7);
        #2 rst = 1'b0;
        #1;
        check_output("t5_col",   32'(new_pipe),   32'h0);
        check_output("t5_start", 32'(pipe_start), 32'h0);
        check_output("t5_gap",   32'(gap_top),    32'h0);
        check_output("t5_count", 32'(pipe_count), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        apply_ticks(7);
        check_output("t5_reseed_col", 32'(new_pipe), 32'hFF87);

        // Sixteen pipes: measure every blank run ahead of each pipe.
        do_reset();
        run = 1'b1;
        zero_run = 0;
        pipes = 0;
        guard = 0;
        while (pipes < 16 && guard < 400) begin
            apply_tick();
            guard++;
            if (pipe_start) begin
                pipes++;
                check_output($sformatf("run_len_p%0d", pipes), 32'(zero_run), 32'(exp_zero_run(pipes)));
                zero_run = 0;
            end else if (new_pipe == 16'h0) begin
                zero_run++;
            end
        end
        check_output("ramp_pipes", 32'(pipes),      32'd16);
        check_output("ramp_count", 32'(pipe_count), 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
